// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the current PC, steps it sequentially while
// running, applies taken branches (relative or absolute) and freezes on halt.
// Start/Running/Done let a top level launch a program and observe completion.
//
// Optional feature macro: PC_CYCLE_CNT_EN
//   When defined, adds the CNT_W parameter and the CycleCnt output, a
//   saturating count of clock edges spent in RUN (halting edge included).
//
// State is exposed on state_dbg for checkers. The encodings are
// 0 = IDLE, 1 = RUN, 2 = DONE, and 3 is unused.
//
// Handshake: Start is a single-cycle request. It is accepted on any edge
// where the registered state is IDLE or DONE and Reset is low, and ignored
// otherwise. Branch and Halt are only honoured on edges where the state is
// RUN.
module pc_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
`ifdef PC_CYCLE_CNT_EN
  ,
  parameter int              CNT_W    = 16
`endif
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Start,
  input  logic [PC_W-1:0] StartAddr,
  input  logic            Branch,
  input  logic            BranchRel,
  input  logic [PC_W-1:0] Target,
  input  logic            Halt,
  output logic [PC_W-1:0] PC,
  output logic            Running,
  output logic            Done,
`ifdef PC_CYCLE_CNT_EN
  output logic [CNT_W-1:0] CycleCnt,
`endif
  output logic [1:0]      state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;

  // Next-state and next-PC selection. In RUN the priority is
  // Halt > Branch > increment. A relative Target is already PC_W wide, so
  // sign-extending it to PC_W is the identity, and the modulo-2^PC_W add
  // handles negative offsets.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          pc_d    = StartAddr;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (Halt) begin
          state_d = S_DONE;
        end else if (Branch) begin
          pc_d = BranchRel ? (pc_q + Target) : Target;
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and PC registers. Reset overrides every other input.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign PC        = pc_q;
  assign Running   = (state_q == S_RUN);
  assign Done      = (state_q == S_DONE);
  assign state_dbg = state_q;

`ifdef PC_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_acc;

  assign start_acc = Start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // RUN-cycle counter: cleared on an accepted Start and saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (start_acc) begin
      cnt_d = '0;
    end else if ((state_q == S_RUN) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CycleCnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer. It covers directed scenarios with literal
// expectations, followed by randomized traffic checked against a behavioural
// model. Define PC_CYCLE_CNT_EN to also check CycleCnt.
module tb_pc_sequencer;

  localparam int PC_W = 8;
  localparam int CNT_W = 16;
  localparam logic [PC_W-1:0] RESET_PC = 8'h00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            start;
  logic [PC_W-1:0] start_addr;
  logic            branch;
  logic            branch_rel;
  logic [PC_W-1:0] target;
  logic            halt;
  logic [PC_W-1:0] pc;
  logic            running;
  logic            done;
  logic [1:0]      state_dbg;
`ifdef PC_CYCLE_CNT_EN
  logic [CNT_W-1:0] cycle_cnt;
`endif

  pc_sequencer #(
    .PC_W(PC_W),
    .RESET_PC(RESET_PC)
`ifdef PC_CYCLE_CNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .CLK(clk),
    .Reset(reset),
    .Start(start),
    .StartAddr(start_addr),
    .Branch(branch),
    .BranchRel(branch_rel),
    .Target(target),
    .Halt(halt),
    .PC(pc),
    .Running(running),
    .Done(done),
`ifdef PC_CYCLE_CNT_EN
    .CycleCnt(cycle_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  // Model phase: 0 idle, 1 running, 2 done.
  int              m_phase;
  logic [PC_W-1:0] m_pc;
  longint          m_cnt;
  logic [PC_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by the rules for one edge using the inputs presented.
  task automatic model_edge();
    if (reset) begin
      m_phase = 0;
      m_pc    = RESET_PC;
      m_cnt   = 0;
    end else if (m_phase == 1) begin
      m_cnt = (m_cnt + 1 > (64'd1 << CNT_W) - 1) ? (64'd1 << CNT_W) - 1 : m_cnt + 1;
      if (halt) m_phase = 2;
      else if (branch) m_pc = branch_rel ? PC_W'((int'(m_pc) + int'($signed(target))) % 256) : target;
      else m_pc = PC_W'((int'(m_pc) + 1) % 256);
    end else if (start) begin
      m_phase = 1;
      m_pc    = start_addr;
      m_cnt   = 0;
    end
    exp_q.push_back(m_pc);
  endtask

  // One clock: apply the edge to the model, then compare outputs #1 later.
  task automatic tick();
    logic [PC_W-1:0] exp_pc;
    @(posedge clk);
    model_edge();
    #1;
    exp_pc = exp_q.pop_front();
    check("pc", pc, exp_pc);
    check("running", running, m_phase == 1);
    check("done", done, m_phase == 2);
    check("excl", running & done, 1'b0);
`ifdef PC_CYCLE_CNT_EN
    check("cycle_cnt", cycle_cnt, m_cnt[CNT_W-1:0]);
`endif
  endtask

  // ---------------- driver helpers ----------------
  task automatic idle_inputs();
    reset = 0; start = 0; branch = 0; branch_rel = 0; halt = 0;
    start_addr = '0; target = '0;
  endtask

  task automatic do_start(input logic [PC_W-1:0] a);
    start = 1; start_addr = a;
    tick();
    start = 0;
  endtask

  task automatic do_halt();
    halt = 1;
    tick();
    halt = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [PC_W-1:0] end_pc;
    idle_inputs();
    m_phase = 0; m_pc = RESET_PC; m_cnt = 0;

    // Reset state.
    do_reset();
    tick();
    check("lit_reset_pc", pc, 8'h00);
    check("lit_reset_run", running, 1'b0);
    check("lit_reset_done", done, 1'b0);

    // Sequential fetch from 0x10.
    do_start(8'h10);
    check("lit_start_pc", pc, 8'h10);
    check("lit_start_run", running, 1'b1);
    tick(); check("lit_seq1", pc, 8'h11);
    tick(); check("lit_seq2", pc, 8'h12);
    tick(); check("lit_seq3", pc, 8'h13);
    do_halt();
    check("lit_halt_done", done, 1'b1);
    check("lit_halt_pc", pc, 8'h13);

    // Relative then absolute branch.
    do_start(8'h20);
    check("lit_pc20", pc, 8'h20);
    branch = 1; branch_rel = 1; target = 8'hFC;
    tick(); check("lit_rel_branch", pc, 8'h1C);
    branch_rel = 0; target = 8'h40;
    tick(); check("lit_abs_branch", pc, 8'h40);
    branch = 0;
    do_halt();

    // Wrap-around.
    do_start(8'hFE);
    check("lit_wrap0", pc, 8'hFE);
    tick(); check("lit_wrap1", pc, 8'hFF);
    tick(); check("lit_wrap2", pc, 8'h00);
    tick(); check("lit_wrap3", pc, 8'h01);

    // Halt at 0x05 with a simultaneous branch; halt wins.
    do_reset();
    do_start(8'h00);
    for (int i = 0; i < 12 && m_phase == 1; i++) begin
      halt   = (m_pc == 8'h05);
      branch = (m_pc == 8'h05);
      target = 8'h99;
      tick();
    end
    check("lit_halt5_done", done, 1'b1);
    check("lit_halt5_run", running, 1'b0);
    check("lit_halt5_pc", pc, 8'h05);
`ifdef PC_CYCLE_CNT_EN
    check("lit_halt5_cnt", cycle_cnt, 16'd6);
`endif
    for (int i = 0; i < 10; i++) begin
      tick();
      check("lit_hold5_pc", pc, 8'h05);
    end
    halt = 0; branch = 0;

    // Restart from DONE at 0x80; Start during RUN is ignored.
    do_start(8'h80);
    check("lit_restart_pc", pc, 8'h80);
    check("lit_restart_done", done, 1'b0);
    check("lit_restart_run", running, 1'b1);
`ifdef PC_CYCLE_CNT_EN
    check("lit_restart_cnt", cycle_cnt, 16'd0);
`endif
    do_start(8'h55);
    check("lit_start_in_run", pc, 8'h81);
    tick(); check("lit_start_in_run2", pc, 8'h82);

    // Reset mid-RUN at 0x33 with Start held high.
    do_halt();
    do_start(8'h30);
    tick(); tick(); tick();
    check("lit_pc33", pc, 8'h33);
    reset = 1; start = 1; start_addr = 8'h77;
    tick();
    check("lit_rst_run_pc", pc, RESET_PC);
    check("lit_rst_run_run", running, 1'b0);
    check("lit_rst_run_done", done, 1'b0);
    reset = 0; start = 0;
    tick();
    check("lit_after_rst_pc", pc, RESET_PC);

    // Randomized traffic with a simple end-PC halt detector.
    end_pc = PC_W'($urandom_range(0, 255));
    for (int i = 0; i < 2000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      start      = ($urandom_range(0, 9) == 0);
      start_addr = PC_W'($urandom_range(0, 255));
      branch     = ($urandom_range(0, 3) == 0);
      branch_rel = $urandom_range(0, 1) == 1;
      target     = PC_W'($urandom_range(0, 255));
      halt       = (m_pc == end_pc) || ($urandom_range(0, 39) == 0);
      if (m_phase == 2 && $urandom_range(0, 3) == 0) end_pc = PC_W'($urandom_range(0, 255));
      tick();
    end
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
